// File: rtl/usb_cdc_in_arbiter.sv
// Round-robin arbiter sharing the usb_cdc IN byte stream among N_REQ valid/ready requesters,
// granting bounded bursts optionally prefixed by a channel header byte (8'hF0 | idx).
module usb_cdc_in_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned HEADER_EN = 1
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               configured_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         in_data_o,
  output logic               in_valid_o,
  input  logic               in_ready_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HDR   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(BURST_LEN - 1);

  logic [1:0]       r_state;
  logic [2:0]       r_grant_idx;
  logic [2:0]       r_last_idx;
  logic [7:0]       r_cnt;
  logic [N_REQ-1:0] r_grant;
  logic             r_busy;

  logic [1:0]       w_state_d;
  logic [2:0]       w_grant_idx_d;
  logic [2:0]       w_last_idx_d;
  logic [7:0]       w_cnt_d;
  logic [N_REQ-1:0] w_grant_d;
  logic [2:0]       w_pick_idx;
  logic             w_pick_vld;
  logic [7:0]       w_gnt_data;
  logic             w_gnt_valid;

  // Pick the valid requester with the smallest rotating distance from last_idx+1.
  always_comb begin
    int unsigned v_dist;
    int unsigned v_best;
    w_pick_idx = '0;
    w_pick_vld = |req_valid_i;
    v_best     = N_REQ;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      v_dist = k + N_REQ - 1 - 32'(r_last_idx);
      if (v_dist >= N_REQ) v_dist = v_dist - N_REQ;
      if (req_valid_i[k] && (v_dist < v_best)) begin
        v_best     = v_dist;
        w_pick_idx = 3'(k);
      end
    end
  end

  always_comb begin
    w_gnt_data  = '0;
    w_gnt_valid = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (r_grant_idx == 3'(k)) begin
        w_gnt_data  = req_data_i[8*k +: 8];
        w_gnt_valid = req_valid_i[k];
      end
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_grant_idx_d = r_grant_idx;
    w_last_idx_d  = r_last_idx;
    w_cnt_d       = r_cnt;
    in_valid_o    = 1'b0;
    in_data_o     = '0;
    req_ready_o   = '0;
    case (r_state)
      ST_HDR: begin
        in_valid_o = 1'b1;
        in_data_o  = 8'hF0 | {5'd0, r_grant_idx};
        if (in_ready_i) begin
          w_state_d = ST_BURST;
        end else if (!configured_i) begin
          w_state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        in_valid_o = w_gnt_valid;
        in_data_o  = w_gnt_data;
        for (int unsigned k = 0; k < N_REQ; k++) begin
          req_ready_o[k] = in_ready_i && (r_grant_idx == 3'(k));
        end
        // A byte moving this cycle always completes; the other exits wait for an idle cycle.
        if (w_gnt_valid && in_ready_i) begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_d   = '0;
            w_state_d = ST_IDLE;
          end else begin
            w_cnt_d = r_cnt + 8'd1;
          end
        end else if (!w_gnt_valid || !configured_i) begin
          w_state_d = ST_IDLE;
        end
      end
      default: begin
        if (configured_i && w_pick_vld) begin
          w_grant_idx_d = w_pick_idx;
          w_last_idx_d  = w_pick_idx;
          w_cnt_d       = '0;
          w_state_d     = (HEADER_EN != 0) ? ST_HDR : ST_BURST;
        end
      end
    endcase
  end

  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_grant_d[k] = (w_state_d != ST_IDLE) && (w_grant_idx_d == 3'(k));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state     <= ST_IDLE;
      r_grant_idx <= '0;
      r_last_idx  <= 3'(N_REQ - 1);
      r_cnt       <= '0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_grant_idx <= w_grant_idx_d;
      r_last_idx  <= w_last_idx_d;
      r_cnt       <= w_cnt_d;
      r_grant     <= w_grant_d;
      r_busy      <= (w_state_d != ST_IDLE);
    end
  end

  assign grant_o = r_grant;
  assign busy_o  = r_busy;

endmodule
